mc_fifo_avlstrm: RTL and testbench
==================================

Name: mc_fifo_avlstrm

Overview:
Multi-channel successor to the single-stream FIFO wrapper. It has NUM_CH independent Avalon-ST ingress FIFOs and one shared egress. A round-robin arbiter sits on the egress and can hold the grant for a whole packet. Each channel reports its own fill level, almost-full and overflow count, plus beat statistics. Used where several parser or lane streams merge into one pipeline on a single clock domain.

Parameters:
NUM_CH, 4, number of ingress channels (2..16)
DATA_W, 512, data bits per beat
DEPTH, 512, entries per channel FIFO (power of 2, >=4)
FULL_LEVEL, 450, fill level at or above which almost_full[c] asserts
PKT_MODE, 1, 1 = grant locked from sop to eop; 0 = re-arbitrate every beat
CH_W, $clog2(NUM_CH), channel index width (derived)
FL_W, $clog2(DEPTH)+1, fill-level width (derived)

Ports:
Clk  in  1  single clock
Rst  in  1  synchronous reset, active-high
in_data  in  NUM_CH*DATA_W  per-channel data, channel c at [c*DATA_W +: DATA_W]
in_valid  in  NUM_CH  per-channel valid
in_sop  in  NUM_CH  start of packet
in_eop  in  NUM_CH  end of packet
in_ready  out  NUM_CH  per-channel ready
out_data  out  DATA_W  egress data
out_valid  out  1  egress valid
out_sop  out  1  egress start of packet
out_eop  out  1  egress end of packet
out_channel  out  CH_W  source channel of the current egress beat
out_ready  in  1  egress ready
almost_full  out  NUM_CH  per-channel fill_level >= FULL_LEVEL
fill_level  out  NUM_CH*FL_W  per-channel occupancy
overflow  out  NUM_CH*32  per-channel count of backpressured beats
stats_in  out  NUM_CH*32  per-channel accepted ingress beats
stats_out  out  32  egress beats transferred

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - all FIFOs emptied; pointers, fill_level, overflow and stats cleared to 0
  - arbiter goes to IDLE with last_grant = NUM_CH-1, so channel 0 has first priority
  - in_ready = 0 during reset
  - out_valid, out_sop, out_eop = 0; out_channel = 0
  - a packet in flight when reset hits is discarded; no partial eop is emitted
- Ingress handshake:
  - a beat is accepted when in_valid[c] & in_ready[c]
  - in_ready[c] = ~full[c] & ~Rst
  - a same-cycle read does not free space for the write; full means fill_level == DEPTH
- Overflow:
  - overflow[c] increments on each cycle with in_valid[c] & ~in_ready[c] outside reset
  - saturates at 32'hFFFFFFFF
- Egress handshake:
  - a beat transfers when out_valid & out_ready
  - out_valid must not depend on out_ready
  - out_* is a combinational mux of the granted channel's head entry
- Latency: a beat written at edge t is visible at the egress from cycle t+1, given an empty FIFO and a granted channel.
- fill_level[c]:
  - +1 on a write, -1 on a read, unchanged on a simultaneous read and write
  - never exceeds DEPTH, never goes below 0
  - read and write pointers are log2(DEPTH) bits, wrap naturally, with a separate count register
- Arbiter FSM:
  - IDLE:
    - grant = first non-empty channel searching from last_grant+1 modulo NUM_CH
    - out_valid = 1 if any channel is non-empty
    - on a transfer: last_grant <= grant
    - if PKT_MODE=1 and the beat is not eop, go to LOCKED with lock_ch = grant
  - LOCKED:
    - grant = lock_ch
    - out_valid = ~empty[lock_ch]; other channels are never selected, even while lock_ch is empty
    - a transfer with eop returns to IDLE
  - PKT_MODE=0: always IDLE
  - a beat with both sop and eop set is a one-beat packet and does not lock
- stats_in[c]: +1 per accepted ingress beat, 32-bit wrap.
- stats_out: +1 per egress transfer, 32-bit wrap.
- The block does not check sop/eop framing; malformed framing passes through unchanged.

Optional Feature:
MC_FIFO_STATS_EN
- Defined: stats_in, stats_out and overflow counters are instantiated as described in Behaviour.
- Not defined: stats_in, stats_out and overflow are tied to 0 and the counters are removed. FIFO and arbiter behaviour is unchanged.

Decomposition:
- Shared package mc_fifo_pkg:
  - arbiter state enum typedef {IDLE, LOCKED}
  - saturating-increment function
  - STATS_W = 32 constant
- One natural sub-module: mc_fifo_ch, a single-clock FIFO of DEPTH x (DATA_W+2) with count, full/empty, almost_full and show-ahead head register. It is instantiated NUM_CH times in a generate loop. The arbiter lives in the top.

Test Plan:
- Reset then idle, NUM_CH=4 → out_valid=0; in_ready=4'hF; all fill_level=0; stats all 0.
- Ch2 writes one beat (sop=eop=1, data=0xA5), out_ready=1 → egress next cycle with out_channel=2 and data 0xA5; stats_in[2]=1; stats_out=1; fill_level[2] returns to 0.
- PKT_MODE=1: ch0 sends a 3-beat packet while ch1 sends a 1-beat packet in the same cycles → egress order is ch0 b0, b1, b2 (eop), then ch1; no interleave; next grant starts search at ch1.
- Channel 3 has DEPTH=8, FULL_LEVEL=6, out_ready=0; 10 valid beats are offered → almost_full[3] after the 6th write; in_ready[3]=0 after the 8th; fill_level[3]=8; overflow[3]=2.
- All 4 channels each hold two 1-beat packets, out_ready=1 → egress channel sequence 0,1,2,3,0,1,2,3.
- Rst pulsed mid-packet in LOCKED on ch1 → next cycle IDLE; fill_level all 0; out_valid=0; no eop emitted; counters 0.

Source files
------------

// File: rtl/mc_fifo_pkg.sv
// Shared types and helpers for the multi-channel Avalon-ST FIFO.
// Holds the arbiter state enum, the counter width and a saturating increment.
package mc_fifo_pkg;

  localparam int STATS_W = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  function automatic logic [STATS_W-1:0] sat_inc(
    input logic [STATS_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mc_fifo_ch.sv
// Single-channel show-ahead FIFO, DEPTH x W, with occupancy count.
// Ports: clk/rst, wr_data/wr_valid/ready (ingress), rd (pop), head/empty, almost_full, count.
module mc_fifo_ch
  import mc_fifo_pkg::*;
#(
  parameter int W          = 514,
  parameter int DEPTH      = 512,
  parameter int FULL_LEVEL = 450,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_valid,
  output logic          ready,
  input  logic          rd,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr;
  logic          pop;

  // count never exceeds DEPTH = 2**AW, so its MSB alone marks full
  assign ready       = ~count[AW] & ~rst;
  assign empty       = (count == '0);
  assign almost_full = 32'(count) >= 32'(FULL_LEVEL);
  assign wr          = wr_valid & ready;
  assign pop         = rd & ~empty;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_fifo_avlstrm.sv
// NUM_CH Avalon-ST ingress FIFOs merged onto one egress by a round-robin arbiter
// that can lock for a whole packet. Ports: Clk/Rst, in_* ingress, out_* egress,
// almost_full/fill_level per channel, overflow/stats_in/stats_out counters.
// Counters exist only when MC_FIFO_STATS_EN is defined; otherwise they read 0.
module mc_fifo_avlstrm
  import mc_fifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 512,
  parameter int DEPTH      = 512,
  parameter int FULL_LEVEL = 450,
  parameter int PKT_MODE   = 1,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int FL_W       = $clog2(DEPTH) + 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_sop,
  input  logic [NUM_CH-1:0]        in_eop,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [CH_W-1:0]          out_channel,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH*FL_W-1:0]   fill_level,
  output logic [NUM_CH*32-1:0]     overflow,
  output logic [NUM_CH*32-1:0]     stats_in,
  output logic [31:0]              stats_out
);

  localparam int W = DATA_W + 2;

  logic [W-1:0]      head [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  arb_state_t        state;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   rr_ch;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              xfer;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mc_fifo_ch #(
      .W          (W),
      .DEPTH      (DEPTH),
      .FULL_LEVEL (FULL_LEVEL)
    ) u_ch (
      .clk         (Clk),
      .rst         (Rst),
      .wr_data     ({in_sop[c], in_eop[c], in_data[c*DATA_W +: DATA_W]}),
      .wr_valid    (in_valid[c]),
      .ready       (in_ready[c]),
      .rd          (pop[c]),
      .head        (head[c]),
      .empty       (empty[c]),
      .almost_full (almost_full[c]),
      .count       (fill_level[c*FL_W +: FL_W])
    );
  end

  // first non-empty channel after last_grant, wrapping at NUM_CH
  always_comb begin
    rr_ch = '0;
    found = 1'b0;
    cand  = last_grant;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
      if (!found && !empty[cand]) begin
        rr_ch = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = Rst ? '0 : (state == LOCKED) ? lock_ch : rr_ch;

  assign out_valid   = ~Rst & ((state == LOCKED) ? ~empty[lock_ch] : found);
  assign out_channel = grant;
  assign out_data    = head[grant][DATA_W-1:0];
  assign out_sop     = out_valid & head[grant][DATA_W+1];
  assign out_eop     = out_valid & head[grant][DATA_W];
  assign xfer        = out_valid & out_ready;

  always_comb begin
    pop = '0;
    if (xfer) pop[grant] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      last_grant <= CH_W'(NUM_CH - 1);
      lock_ch    <= '0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          last_grant <= grant;
          if (PKT_MODE != 0 && !out_eop) begin
            state   <= LOCKED;
            lock_ch <= grant;
          end
        end
        LOCKED: if (out_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MC_FIFO_STATS_EN
  logic [STATS_W-1:0] ovf_q [NUM_CH];
  logic [STATS_W-1:0] sin_q [NUM_CH];
  logic [STATS_W-1:0] sout_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ovf_q[c] <= '0;
        sin_q[c] <= '0;
      end
      sout_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[c] & ~in_ready[c]) ovf_q[c] <= sat_inc(ovf_q[c]);
        if (in_valid[c] & in_ready[c])  sin_q[c] <= sin_q[c] + 1'b1;
      end
      if (xfer) sout_q <= sout_q + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_st
    assign overflow[c*32 +: 32] = ovf_q[c];
    assign stats_in[c*32 +: 32] = sin_q[c];
  end
  assign stats_out = sout_q;
`else
  assign overflow  = '0;
  assign stats_in  = '0;
  assign stats_out = '0;
`endif

endmodule

// File: tb/tb_mc_fifo_avlstrm.sv
// Directed self-checking bench for mc_fifo_avlstrm.
// Small config: 4 channels, 16-bit data, 8-deep FIFOs, almost-full at 6.
module tb_mc_fifo_avlstrm;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int DEP  = 8;
  localparam int FL   = 6;
  localparam int CHW  = 2;
  localparam int FLW  = 4;
`ifdef MC_FIFO_STATS_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic              Clk;
  logic              Rst;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_sop;
  logic [NCH-1:0]    in_eop;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [CHW-1:0]    out_channel;
  logic              out_ready;
  logic [NCH-1:0]    almost_full;
  logic [NCH*FLW-1:0] fill_level;
  logic [NCH*32-1:0] overflow;
  logic [NCH*32-1:0] stats_in;
  logic [31:0]       stats_out;

  int n_chk = 0;
  int n_fail = 0;

  mc_fifo_avlstrm #(
    .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP),
    .FULL_LEVEL(FL), .PKT_MODE(1)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop),
    .out_channel(out_channel), .out_ready(out_ready),
    .almost_full(almost_full), .fill_level(fill_level),
    .overflow(overflow), .stats_in(stats_in), .stats_out(stats_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] st(input int v);
    return SE ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_data  = '0;
  endtask

  task automatic beat(input int c, input bit s, input bit e,
                      input logic [DW-1:0] d);
    in_valid[c] = 1'b1;
    in_sop[c]   = s;
    in_eop[c]   = e;
    in_data[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle_in();
    out_ready = 1'b0;
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    out_ready = 1'b0;
    Rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_ready_in_reset: got %h expected 0", in_ready);
    end
    Rst = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out: got v%b s%b e%b expected 000",
               out_valid, out_sop, out_eop);
    end
    n_chk++;
    if (in_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_ready: got %h expected f", in_ready);
    end
    n_chk++;
    if (fill_level !== '0 || out_channel !== '0) begin
      n_fail++;
      $display("FAIL rst_fill: got %h ch %0d expected 0",
               fill_level, out_channel);
    end
    n_chk++;
    if (stats_in !== '0 || overflow !== '0 || stats_out !== '0) begin
      n_fail++;
      $display("FAIL rst_stats: got %h %h %h expected 0",
               stats_in, overflow, stats_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    beat(2, 1, 1, 16'h00A5);
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pre: got valid %b expected 0", out_valid);
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_channel !== 2'd2 ||
        out_data !== 16'h00A5 || out_sop !== 1'b1 || out_eop !== 1'b1) begin
      n_fail++;
      $display("FAIL single_egress: got v%b ch%0d d%h s%b e%b expected 1 2 a5 1 1",
               out_valid, out_channel, out_data, out_sop, out_eop);
    end
    n_chk++;
    if (fill_level[2*FLW +: FLW] !== 4'd1) begin
      n_fail++;
      $display("FAIL single_fill1: got %0d expected 1",
               fill_level[2*FLW +: FLW]);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || fill_level !== '0) begin
      n_fail++;
      $display("FAIL single_drain: got v%b fill %h expected 0 0",
               out_valid, fill_level);
    end
    n_chk++;
    if (stats_in[2*32 +: 32] !== st(1) || stats_out !== st(1)) begin
      n_fail++;
      $display("FAIL single_stats: got %0d %0d expected %0d",
               stats_in[2*32 +: 32], stats_out, st(1));
    end
  endtask

  task automatic test_packet();
    do_reset();
    out_ready = 1'b1;
    beat(0, 1, 0, 16'h0100);
    beat(1, 1, 1, 16'h1100);
    tick();
    idle_in();
    beat(0, 0, 0, 16'h0101);
    #1;
    n_chk++;
    if (out_channel !== 2'd0 || out_data !== 16'h0100 || out_sop !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_b0: got ch%0d d%h s%b expected 0 0100 1",
               out_channel, out_data, out_sop);
    end
    tick();
    idle_in();
    beat(0, 0, 1, 16'h0102);
    #1;
    n_chk++;
    if (out_channel !== 2'd0 || out_data !== 16'h0101 ||
        fill_level[0 +: FLW] !== 4'd1) begin
      n_fail++;
      $display("FAIL pkt_b1: got ch%0d d%h fill%0d expected 0 0101 1",
               out_channel, out_data, fill_level[0 +: FLW]);
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if (out_channel !== 2'd0 || out_data !== 16'h0102 || out_eop !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_b2: got ch%0d d%h e%b expected 0 0102 1",
               out_channel, out_data, out_eop);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_channel !== 2'd1 || out_data !== 16'h1100) begin
      n_fail++;
      $display("FAIL pkt_ch1: got v%b ch%0d d%h expected 1 1 1100",
               out_valid, out_channel, out_data);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || stats_out !== st(4)) begin
      n_fail++;
      $display("FAIL pkt_end: got v%b so%0d expected 0 %0d",
               out_valid, stats_out, st(4));
    end
  endtask

  task automatic test_full();
    int f;
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      beat(3, 1, 1, 16'(k));
      tick();
      f = (k > DEP) ? DEP : k;
      n_chk++;
      if (fill_level[3*FLW +: FLW] !== 4'(f) ||
          almost_full[3] !== (f >= FL) || in_ready[3] !== (f < DEP)) begin
        n_fail++;
        $display("FAIL full_step%0d: got fill%0d af%b rdy%b expected %0d %b %b",
                 k, fill_level[3*FLW +: FLW], almost_full[3], in_ready[3],
                 f, f >= FL, f < DEP);
      end
    end
    idle_in();
    #1;
    n_chk++;
    if (overflow[3*32 +: 32] !== st(2) || stats_in[3*32 +: 32] !== st(8)) begin
      n_fail++;
      $display("FAIL full_ovf: got ovf%0d in%0d expected %0d %0d",
               overflow[3*32 +: 32], stats_in[3*32 +: 32], st(2), st(8));
    end
    n_chk++;
    if (out_valid !== 1'b1 || almost_full !== 4'h8) begin
      n_fail++;
      $display("FAIL full_hold: got v%b af%h expected 1 8", out_valid, almost_full);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= DEP; k++) begin
      #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_channel !== 2'd3 || out_data !== 16'(k)) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v%b ch%0d d%h expected 1 3 %h",
                 k, out_valid, out_channel, out_data, 16'(k));
      end
      tick();
    end
    n_chk++;
    if (out_valid !== 1'b0 || fill_level !== '0) begin
      n_fail++;
      $display("FAIL full_empty: got v%b fill %h expected 0 0", out_valid, fill_level);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NCH; c++) beat(c, 1, 1, {4'(c), 4'h0, 8'(b)});
      tick();
    end
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_channel !== 2'(i % 4) ||
          out_data !== {4'(i % 4), 4'h0, 8'(i / 4)}) begin
        n_fail++;
        $display("FAIL rr_%0d: got v%b ch%0d d%h expected 1 %0d %h",
                 i, out_valid, out_channel, out_data, i % 4,
                 {4'(i % 4), 4'h0, 8'(i / 4)});
      end
      tick();
    end
    n_chk++;
    if (out_valid !== 1'b0 || stats_out !== st(8)) begin
      n_fail++;
      $display("FAIL rr_end: got v%b so%0d expected 0 %0d",
               out_valid, stats_out, st(8));
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b1;
    beat(1, 1, 0, 16'h2200);
    tick();
    idle_in();
    beat(0, 1, 1, 16'h3300);
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_channel !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_grant: got v%b ch%0d expected 1 1", out_valid, out_channel);
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || fill_level[0 +: FLW] !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_locked: got v%b fill0 %0d expected 0 1",
               out_valid, fill_level[0 +: FLW]);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_eop !== 1'b0 || fill_level !== '0) begin
      n_fail++;
      $display("FAIL mid_rst: got v%b e%b fill %h expected 0 0 0",
               out_valid, out_eop, fill_level);
    end
    n_chk++;
    if (stats_in !== '0 || stats_out !== '0 || overflow !== '0) begin
      n_fail++;
      $display("FAIL mid_cnt: got %h %h %h expected 0",
               stats_in, stats_out, overflow);
    end
    beat(0, 1, 1, 16'h4400);
    tick();
    idle_in();
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_data !== 16'h4400) begin
      n_fail++;
      $display("FAIL mid_idle: got v%b ch%0d d%h expected 1 0 4400",
               out_valid, out_channel, out_data);
    end
    tick();
  endtask

  initial begin
    Rst = 1'b1;
    out_ready = 1'b0;
    idle_in();
    test_reset();
    test_single();
    test_packet();
    test_full();
    test_round_robin();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
